timer_arbiter: RTL and testbench

TIMER_ARBITER -- requirements
Module: timer_arbiter

---
 rtl/timer_arbiter.sv | 130 +++++++++++++
 tb/tb_timer_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_arbiter.sv
// Round-robin arbiter granting one shared delay timer; the owner gets a one-cycle done pulse when its delay expires.
// Optional abort on request withdrawal is built when TIMER_ARBITER_ABORT_EN is defined.
module timer_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int CLK_COUNT = 100
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic [NUM_REQ-1:0]         done,
  output logic                       busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(CLK_COUNT);

  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_COUNT - 1);
  localparam logic [IW-1:0] ID_LAST  = IW'(NUM_REQ - 1);
  localparam logic [IW:0]   REQ_W    = (IW + 1)'(NUM_REQ);

`ifdef TIMER_ARBITER_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [IW-1:0]       r_ptr;
  logic [IW-1:0]       r_grant_id;
  logic [NUM_REQ-1:0]  r_grant;
  logic [NUM_REQ-1:0]  r_done;
  logic                r_busy;

  logic [2*NUM_REQ-1:0] w_req2;
  logic [NUM_REQ-1:0]   w_rot;
  logic [IW-1:0]        w_off;
  logic [IW:0]          w_sum;
  logic [IW-1:0]        w_sel_id;
  logic                 w_sel_valid;
  logic [IW-1:0]        w_next_ptr;

  // Rotate requests so the client at r_ptr sits at bit 0; the lowest set bit is the winner.
  assign w_req2      = {req, req};
  assign w_rot       = w_req2[{1'b0, r_ptr} +: NUM_REQ];
  assign w_sel_valid = |req;

  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    w_off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = IW'(i);
    end
  end

  assign w_sum      = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_sel_id   = (w_sum >= REQ_W) ? IW'(w_sum - REQ_W) : IW'(w_sum);
  assign w_next_ptr = (r_grant_id == ID_LAST) ? '0 : r_grant_id + IW'(1);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_ptr      <= '0;
      r_grant    <= '0;
      r_grant_id <= '0;
      r_done     <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_done <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (w_sel_valid) begin
            r_state    <= S_RUN;
            r_cnt      <= '0;
            r_grant_id <= w_sel_id;
            r_grant    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_sel_id;
            r_busy     <= 1'b1;
          end else begin
            r_grant <= '0;
          end
        end

        S_RUN: begin
          if (ABORT_EN && !req[r_grant_id]) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_ptr   <= w_next_ptr;
          end else if (!enable) begin
            // A stall restarts the delay rather than pausing it.
            r_cnt <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= S_DONE;
            r_cnt   <= '0;
            r_done  <= r_grant;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_ptr   <= w_next_ptr;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant    = r_grant;
  assign grant_id = r_grant_id;
  assign done     = r_done;
  assign busy     = r_busy;

endmodule

// File: tb/tb_timer_arbiter.sv
// Self-checking bench for timer_arbiter (NUM_REQ=4, CLK_COUNT=5): vector table plus hand sequences,
// with grant/done expectations queued at stimulus time and matched by a monitor as the DUT responds.
module tb_timer_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int CLK_COUNT = 5;
  localparam int DONE_OFS  = CLK_COUNT + 1;
  localparam int SPACING   = CLK_COUNT + 2;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable  = 1'b1;
  logic [3:0] req     = 4'b0000;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic [3:0] done;
  logic       busy;

  timer_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .CLK_COUNT(CLK_COUNT)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .req     (req),
    .grant   (grant),
    .grant_id(grant_id),
    .done    (done),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0] vec;
    int         cyc;
  } exp_t;

  exp_t gq[$];
  exp_t dq[$];
  exp_t mon_e;

  typedef struct {
    logic [3:0] req;
    logic [3:0] exp_grant;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] idx_of(input logic [3:0] v);
    for (int i = 0; i < 4; i++) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  task automatic push_grant(input logic [3:0] v, input int c);
    exp_t e;
    e.vec = v;
    e.cyc = c;
    gq.push_back(e);
  endtask

  task automatic push_done(input logic [3:0] v, input int c);
    exp_t e;
    e.vec = v;
    e.cyc = c;
    dq.push_back(e);
  endtask

  task automatic wait_done(input logic [3:0] mask, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((done & mask) == 4'b0000 && n < budget);
    check("done_seen", 32'((done & mask) != 4'b0000), 32'd1);
  endtask

  // Monitor: a rising grant or any done pulse consumes the oldest expectation.
  logic [3:0] prev_grant = 4'b0000;
  always @(negedge clk) begin
    if (reset_n) begin
      if (grant != 4'b0000 && prev_grant == 4'b0000) begin
        if (gq.size() == 0) begin
          check("unexpected_grant", grant, 32'd0);
        end else begin
          mon_e = gq.pop_front();
          check("grant_vec", grant, mon_e.vec);
          check("grant_id", grant_id, idx_of(mon_e.vec));
          check("grant_cycle", cyc, mon_e.cyc);
        end
      end
      if (done != 4'b0000) begin
        if (dq.size() == 0) begin
          check("unexpected_done", done, 32'd0);
        end else begin
          mon_e = dq.pop_front();
          check("done_vec", done, mon_e.vec);
          check("done_cycle", cyc, mon_e.cyc);
          check("grant_during_done", grant, mon_e.vec);
        end
      end
    end
    prev_grant = grant;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int s;
    int ids[5];

    // Round-robin expectations from ptr=0 after reset, each vector a complete transaction.
    vecs[0] = '{req: 4'b0001, exp_grant: 4'b0001};
    vecs[1] = '{req: 4'b1111, exp_grant: 4'b0010};
    vecs[2] = '{req: 4'b0011, exp_grant: 4'b0001};
    vecs[3] = '{req: 4'b1000, exp_grant: 4'b1000};
    vecs[4] = '{req: 4'b0110, exp_grant: 4'b0010};
    vecs[5] = '{req: 4'b1101, exp_grant: 4'b0100};
    vecs[6] = '{req: 4'b0101, exp_grant: 4'b0001};
    ids = '{0, 1, 2, 3, 0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_grant", grant, 32'd0);
    check("rst_grant_id", grant_id, 32'd0);
    check("rst_done", done, 32'd0);
    check("rst_busy", busy, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_no_req_grant", grant, 32'd0);
    check("idle_no_req_busy", busy, 32'd0);

    // Single request, cycle-by-cycle
    s   = cyc;
    req = 4'b0001;
    push_grant(4'b0001, s + 1);
    push_done(4'b0001, s + DONE_OFS);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      check($sformatf("single_grant_c%0d", c), grant, (c <= 6) ? 32'd1 : 32'd0);
      check($sformatf("single_done_c%0d", c), done, (c == 6) ? 32'd1 : 32'd0);
      check($sformatf("single_busy_c%0d", c), busy, (c <= 6) ? 32'd1 : 32'd0);
      if (c == 6) req = 4'b0000;
    end

    // Reset mid-RUN: ptr is 1 here, so client 1 wins, then gets discarded
    s   = cyc;
    req = 4'b1111;
    push_grant(4'b0010, s + 1);
    repeat (3) @(negedge clk);
    check("pre_reset_grant", grant, 32'h2);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_grant", grant, 32'd0);
    check("async_rst_busy", busy, 32'd0);
    check("async_rst_done", done, 32'd0);
    check("async_rst_grant_id", grant_id, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // All four held: order 0,1,2,3,0 starting from the reset pointer
    s = cyc;
    for (int k = 0; k < 5; k++) begin
      push_grant(4'b0001 << ids[k], s + 1 + SPACING * k);
      push_done(4'b0001 << ids[k], s + DONE_OFS + SPACING * k);
    end
    repeat (DONE_OFS + SPACING * 4) @(negedge clk);
    req = 4'b0000;
    @(negedge clk);
    check("rr_end_busy", busy, 32'd0);

    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Vector table
    for (int v = 0; v < 7; v++) begin
      s   = cyc;
      req = vecs[v].req;
      push_grant(vecs[v].exp_grant, s + 1);
      push_done(vecs[v].exp_grant, s + DONE_OFS);
      @(negedge clk);
      check($sformatf("tbl%0d_grant", v), grant, vecs[v].exp_grant);
      check($sformatf("tbl%0d_busy", v), busy, 32'd1);
      wait_done(vecs[v].exp_grant, 2 * DONE_OFS);
      req = 4'b0000;
      @(negedge clk);
      check($sformatf("tbl%0d_idle_busy", v), busy, 32'd0);
      check($sformatf("tbl%0d_idle_grant_id", v), grant_id, idx_of(vecs[v].exp_grant));
    end

    // Enable dropped for two cycles after four counting cycles: done at 6+4+2
    s   = cyc;
    req = 4'b0001;
    push_grant(4'b0001, s + 1);
    push_done(4'b0001, s + DONE_OFS + 4 + 2);
    repeat (5) @(negedge clk);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    enable = 1'b1;
    repeat (4) @(negedge clk);
    check("stall_no_early_done", done, 32'd0);
    check("stall_busy", busy, 32'd1);
    wait_done(4'b0001, 5);
    req = 4'b0000;
    @(negedge clk);

    // Client 1 withdraws its request in RUN while client 2 waits
    s   = cyc;
    req = 4'b0110;
    push_grant(4'b0010, s + 1);
    repeat (3) @(negedge clk);
    req = 4'b0100;
`ifdef TIMER_ARBITER_ABORT_EN
    push_grant(4'b0100, s + 5);
    push_done(4'b0100, s + 5 + CLK_COUNT);
    @(negedge clk);
    check("abort_grant", grant, 32'd0);
    check("abort_busy", busy, 32'd0);
`else
    push_done(4'b0010, s + DONE_OFS);
    push_grant(4'b0100, s + SPACING + 1);
    push_done(4'b0100, s + SPACING + DONE_OFS);
    @(negedge clk);
    check("no_abort_grant", grant, 32'h2);
    check("no_abort_busy", busy, 32'd1);
`endif
    wait_done(4'b0100, 20);
    req = 4'b0000;
    repeat (4) @(negedge clk);

    check("grant_queue_empty", gq.size(), 32'd0);
    check("done_queue_empty", dq.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
